// File: rtl/dpa_seq_alu.sv
// Multi-cycle add/sub ALU: sums CHUNK bits per clock through a rippled carry register, valid/ready on both sides.
// Optional clamping of signed overflow results when DPA_SEQ_SATURATE_EN is defined.
module dpa_seq_alu #(
    parameter int unsigned N     = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [4:0]   aluop,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         negative_flag,
    output logic         overflow_flag,
    output logic         zero_flag,
    output logic         op_err
);
    localparam int unsigned STAGES = N / CHUNK;
    localparam int unsigned CW     = (STAGES > 1) ? $clog2(STAGES) : 1;

    localparam logic [4:0] OP_ADDS = 5'b00001;
    localparam logic [4:0] OP_ADDU = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic [4:0]     op_q, op_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           in_ready_d, out_valid_d, cout_d, neg_d, ovf_d, zero_d, err_d;
    logic [N-1:0]   result_d;

    logic           op_legal, op_signed;
    logic [CHUNK:0] sum;
    logic [N-1:0]   res_v;
    logic           ovf_v;
    int unsigned    off;

    assign op_legal  = (op_q == OP_ADDS) || (op_q == OP_ADDU) || (op_q == OP_SUB);
    assign op_signed = (op_q == OP_ADDS) || (op_q == OP_SUB);

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        result_d    = result;
        cout_d      = cout;
        neg_d       = negative_flag;
        ovf_d       = overflow_flag;
        zero_d      = zero_flag;
        err_d       = op_err;
        sum         = '0;
        res_v       = '0;
        ovf_v       = 1'b0;
        off         = CHUNK * 32'(cnt_q);

        case (state_q)
            IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (in_valid && in_ready) begin
                    a_d        = a;
                    b_d        = (aluop == OP_SUB) ? ~b : b;
                    op_d       = aluop;
                    carry_d    = (aluop == OP_SUB);
                    cnt_d      = '0;
                    result_d   = '0;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                in_ready_d = 1'b0;
                if (!op_legal) begin
                    result_d    = '0;
                    cout_d      = 1'b0;
                    neg_d       = 1'b0;
                    ovf_d       = 1'b0;
                    zero_d      = 1'b1;
                    err_d       = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    sum = {1'b0, a_q[off +: CHUNK]} + {1'b0, b_q[off +: CHUNK]}
                        + (CHUNK+1)'(carry_q);
                    result_d[off +: CHUNK] = sum[CHUNK-1:0];
                    carry_d = sum[CHUNK];
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(STAGES - 1)) begin
                        res_v = result_d;
                        ovf_v = op_signed ? ((a_q[N-1] == b_q[N-1]) && (res_v[N-1] != a_q[N-1]))
                                          : sum[CHUNK];
`ifdef DPA_SEQ_SATURATE_EN
                        if (op_signed && ovf_v) begin
                            res_v = a_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
                        end
`endif
                        result_d    = res_v;
                        cout_d      = sum[CHUNK];
                        neg_d       = op_signed & res_v[N-1];
                        ovf_d       = ovf_v;
                        zero_d      = (res_v == '0);
                        err_d       = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                in_ready_d = 1'b0;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    // State, operand and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            carry_q       <= 1'b0;
            cnt_q         <= '0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            result        <= '0;
            cout          <= 1'b0;
            negative_flag <= 1'b0;
            overflow_flag <= 1'b0;
            zero_flag     <= 1'b0;
            op_err        <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            carry_q       <= carry_d;
            cnt_q         <= cnt_d;
            in_ready      <= in_ready_d;
            out_valid     <= out_valid_d;
            result        <= result_d;
            cout          <= cout_d;
            negative_flag <= neg_d;
            overflow_flag <= ovf_d;
            zero_flag     <= zero_d;
            op_err        <= err_d;
        end
    end
endmodule

// File: tb/tb_dpa_seq_alu.sv
// Self-checking bench for dpa_seq_alu (N=32, CHUNK=8): vector table, handshake/reset corner cases, random ops vs model.
// Expectations follow DPA_SEQ_SATURATE_EN when it is defined.
module tb_dpa_seq_alu;
    localparam int unsigned N      = 32;
    localparam int unsigned CHUNK  = 8;
    localparam int unsigned STAGES = N / CHUNK;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  a_i = '0;
    logic [N-1:0]  b_i = '0;
    logic [4:0]    aluop = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  result;
    logic          cout, negative_flag, overflow_flag, zero_flag, op_err;

    int checks = 0;
    int errors = 0;

    dpa_seq_alu #(.N(N), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a_i), .b(b_i), .aluop(aluop), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .negative_flag(negative_flag),
        .overflow_flag(overflow_flag), .zero_flag(zero_flag), .op_err(op_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b, res;
        logic        co, ng, ov, z, er;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain wide arithmetic on the operation's meaning
    function automatic vec_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        longint s;
        logic [32:0] u;
        logic sgn;
        v.op = op; v.a = a; v.b = b; v.er = 1'b0; v.lat = STAGES;
        s = 0; sgn = 1'b0;
        case (op)
            5'b00001: begin
                u = {1'b0, a} + {1'b0, b};
                v.res = u[31:0]; v.co = u[32];
                s = longint'($signed(a)) + longint'($signed(b));
                v.ov = (s > SMAX) || (s < SMIN); sgn = 1'b1;
            end
            5'b00010: begin
                u = {1'b0, a} + {1'b0, b};
                v.res = u[31:0]; v.co = u[32]; v.ov = u[32];
            end
            5'b00011: begin
                v.res = a - b; v.co = (a >= b);
                s = longint'($signed(a)) - longint'($signed(b));
                v.ov = (s > SMAX) || (s < SMIN); sgn = 1'b1;
            end
            default: begin
                v.res = '0; v.co = 1'b0; v.ng = 1'b0; v.ov = 1'b0; v.z = 1'b1; v.er = 1'b1; v.lat = 1;
                return v;
            end
        endcase
`ifdef DPA_SEQ_SATURATE_EN
        if (sgn && v.ov) v.res = (s > 0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
        v.ng = sgn & v.res[31];
        v.z  = (v.res == 32'h0);
        return v;
    endfunction

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        int w = 0;
        while (!in_ready && w < 20) begin step(); w++; end
        chk("in_ready_before_issue", 64'(in_ready), 64'd1);
        in_valid = 1'b1; aluop = op; a_i = a; b_i = b;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin step(); lat++; end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        issue(v.op, v.a, v.b, lat);
        chk({tag, ".latency"}, 64'(lat), 64'(v.lat));
        chk({tag, ".result"}, 64'(result), 64'(v.res));
        chk({tag, ".cout"}, 64'(cout), 64'(v.co));
        chk({tag, ".neg"}, 64'(negative_flag), 64'(v.ng));
        chk({tag, ".ovf"}, 64'(overflow_flag), 64'(v.ov));
        chk({tag, ".zero"}, 64'(zero_flag), 64'(v.z));
        chk({tag, ".op_err"}, 64'(op_err), 64'(v.er));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".out_valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, ".in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".result"}, 64'(result), 64'd0);
        chk({tag, ".flags"}, 64'({cout, negative_flag, overflow_flag, zero_flag, op_err}), 64'd0);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] hold_res;
        vec_t v;

        //           op        a             b             res           co    ng    ov    z     er    lat
`ifdef DPA_SEQ_SATURATE_EN
        vecs[0] = '{5'b00001, 32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4};
        vecs[5] = '{5'b00011, 32'h80000000, 32'h00000001, 32'h80000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4};
`else
        vecs[0] = '{5'b00001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4};
        vecs[5] = '{5'b00011, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4};
`endif
        vecs[1] = '{5'b00010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4};
        vecs[2] = '{5'b00011, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4};
        vecs[3] = '{5'b00011, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4};
        vecs[4] = '{5'b00111, 32'h00000003, 32'h00000004, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        vecs[6] = '{5'b00001, 32'h00FF00FF, 32'h0001FF01, 32'h01010000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4};
        vecs[7] = '{5'b00000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1};

        // Reset state
        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();
        chk("reset_release.in_ready", 64'(in_ready), 64'd1);
        chk("reset_release.out_valid", 64'(out_valid), 64'd0);

        for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Consumer stall in DONE: outputs hold, new requests refused
        issue(5'b00001, 32'h12345678, 32'h11111111, lat);
        chk("stall.latency", 64'(lat), 64'(STAGES));
        hold_res = result;
        chk("stall.result", 64'(hold_res), 64'h23456789);
        in_valid = 1'b1; aluop = 5'b00001; a_i = 32'h1; b_i = 32'h1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.hold_result", 64'(result), 64'(hold_res));
            chk("stall.hold_valid", 64'(out_valid), 64'd1);
            chk("stall.in_ready_low", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("stall.release_idle", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin step(); if (out_valid) seen++; end
        chk("stall.no_ghost_accept", 64'(seen), 64'd0);

        // Reset during BUSY chunk 2
        in_valid = 1'b1; aluop = 5'b00011; a_i = 32'h00000009; b_i = 32'h00000002;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin step(); if (out_valid) seen++; end
        chk("midreset.no_out_valid", 64'(seen), 64'd0);
        run_vec("after_reset", model(5'b00011, 32'h00000009, 32'h00000002));

        // Random ops against the model
        for (int i = 0; i < 200; i++) begin
            int r;
            logic [4:0] op;
            logic [31:0] ra, rb;
            r  = $urandom_range(0, 4);
            op = (r >= 3) ? 5'($urandom) : 5'(r + 1);
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = {ra[31], 31'h7FFFFFFF ^ {31{ra[30]}}};
            if ($urandom_range(0, 5) == 0) rb = ra;
            v = model(op, ra, rb);
            run_vec($sformatf("rand%0d", i), v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
